// File: rtl/traffic_phase_timer_if.sv
// Phase timer <-> traffic FSM / button bundle.
// The DUT side takes the slave view.
interface traffic_phase_timer_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       enableCounters;
    logic             pedButton;
    logic             nextEvent;
    logic             pedRequest;
    logic [CNT_W-1:0] remaining;
    logic             phaseFault;

    modport master (
        output enableCounters,
        output pedButton,
        input  nextEvent,
        input  pedRequest,
        input  remaining,
        input  phaseFault
    );

    modport slave (
        input  enableCounters,
        input  pedButton,
        output nextEvent,
        output pedRequest,
        output remaining,
        output phaseFault
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// Times the active traffic phase and pulses nextEvent on expiry;
// also latches pedestrian requests until the walk phase is served.
module traffic_phase_timer #(
    parameter int TICK_DIV   = 50,
    parameter int CNT_W      = 8,
    parameter int DUR_GREEN  = 10,
    parameter int DUR_YELLOW = 3,
    parameter int DUR_RED    = 2,
    parameter int DUR_WALK   = 8
) (
    input logic                  clk,
    input logic                  reset,
    traffic_phase_timer_if.slave bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EXPIRED,
        FAULT
    } state_t;

    state_t state;
    state_t stateNext;

    logic [3:0]       en;
    logic [3:0]       enPrev;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] remainingQ;
    logic [CNT_W-1:0] dur;
    logic             nextEventQ;
    logic             pedReqQ;
    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             riseQ;
    logic             change;
    logic             zero;
    logic             multi;
    logic             tick;
    logic             expire;

    function automatic logic [CNT_W-1:0] fixDur(input int d);
        return (d == 0) ? ONE : CNT_W'(d);
    endfunction

    assign en     = bus.enableCounters;
    assign change = (en != enPrev);
    assign zero   = (en == 4'b0000);
    assign multi  = !zero && !$onehot(en);
    assign tick   = (state == RUN) && (presc == PMAX);
    // A phase change in the expiry cycle reloads instead of pulsing.
    assign expire = tick && (remainingQ == ONE) && !change;

    always_comb begin
        dur = '0;
        unique case (en)
            4'b0001: dur = fixDur(DUR_GREEN);
            4'b0010: dur = fixDur(DUR_YELLOW);
            4'b0100: dur = fixDur(DUR_RED);
            4'b1000: dur = fixDur(DUR_WALK);
            default: dur = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (multi) begin
            stateNext = FAULT;
        end else if (change) begin
            stateNext = zero ? IDLE : RUN;
        end else if (expire) begin
            stateNext = EXPIRED;
        end
    end

    always_comb begin
        bus.phaseFault = (state == FAULT);
        bus.nextEvent  = nextEventQ;
        bus.remaining  = remainingQ;
        bus.pedRequest = pedReqQ;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enPrev     <= 4'b0000;
            presc      <= '0;
            remainingQ <= '0;
            nextEventQ <= 1'b0;
        end else begin
            enPrev     <= en;
            nextEventQ <= expire;
            if (change || (state != RUN) || tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
            if (multi || (change && zero)) begin
                remainingQ <= '0;
            end else if (change) begin
                remainingQ <= dur;
            end else if (tick && (remainingQ != '0)) begin
                remainingQ <= remainingQ - ONE;
            end
        end
    end

    // Two-flop synchroniser, then a registered rising-edge detect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync3   <= 1'b0;
            riseQ   <= 1'b0;
            pedReqQ <= 1'b0;
        end else begin
            sync1 <= bus.pedButton;
            sync2 <= sync1;
            sync3 <= sync2;
            riseQ <= sync2 & ~sync3;
            if (riseQ && !en[3]) begin
                pedReqQ <= 1'b1;
            end else if (enPrev[3] && !en[3]) begin
                pedReqQ <= 1'b0;
            end
        end
    end
endmodule
